// File: rtl/ganesha_pkg.sv
// ganesha_pkg: shared geometry defaults and FSM encoding
// for the ganesha scan controller.
package ganesha_pkg;

    localparam int ROWS_DEF   = 32;
    localparam int COLS_DEF   = 64;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        SHIFT = 2'd3
    } scan_state_t;

endpackage

// File: rtl/ganesha_scan_ctrl_if.sv
// ganesha_scan_ctrl_if: control, ROM and pixel-stream bundle.
// master is the scan controller, slave is the ROM/sink side.
interface ganesha_scan_ctrl_if
    import ganesha_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int COLS   = COLS_DEF,
    parameter int COL_W  = $clog2(COLS)
);
    logic              start;
    logic              loop;
    logic              abort;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [COLS-1:0]   rom_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_data;
    logic [ADDR_W-1:0] pix_row;
    logic [COL_W-1:0]  pix_col;
    logic              pix_eol;
    logic              pix_eof;
    logic              busy;
    logic              done;
    logic [7:0]        frame_cnt;

    modport master (
        input  start, loop, abort, rom_data, pix_ready,
        output rom_en, rom_addr, pix_valid, pix_data,
        output pix_row, pix_col, pix_eol, pix_eof,
        output busy, done, frame_cnt
    );

    modport slave (
        output start, loop, abort, rom_data, pix_ready,
        input  rom_en, rom_addr, pix_valid, pix_data,
        input  pix_row, pix_col, pix_eol, pix_eof,
        input  busy, done, frame_cnt
    );
endinterface

// File: rtl/scan_row_shifter.sv
// scan_row_shifter: holds one ROM row and walks it MSB-first,
// tracking which column is currently presented.
module scan_row_shifter #(
    parameter int COLS  = 64,
    parameter int COL_W = $clog2(COLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [COLS-1:0]  din,
    input  logic             shift,
    output logic             bit_out,
    output logic [COL_W-1:0] col,
    output logic             last
);
    logic [COLS-1:0]  sr;
    logic [COL_W-1:0] col_q;

    // Load a fresh row, or advance one pixel per accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr    <= '0;
            col_q <= '0;
        end else if (load) begin
            sr    <= din;
            col_q <= '0;
        end else if (shift) begin
            sr    <= {sr[COLS-2:0], 1'b0};
            col_q <= col_q + COL_W'(1);
        end
    end

    assign bit_out = sr[COLS-1];
    assign col     = col_q;
    assign last    = (col_q == COL_W'(COLS - 1));

endmodule

// File: rtl/ganesha_scan_ctrl.sv
// ganesha_scan_ctrl: fetches image rows from an external ROM
// and streams them out one pixel per accepted beat.
module ganesha_scan_ctrl
    import ganesha_pkg::*;
#(
    parameter int ROWS   = ROWS_DEF,
    parameter int COLS   = COLS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic clk,
    input  logic rst,
    ganesha_scan_ctrl_if.master bus
);
    localparam int COL_W = $clog2(COLS);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

    scan_state_t       state;
    logic [ADDR_W-1:0] row;
    logic [COL_W-1:0]  col;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [7:0]        frame_q;
    logic              rom_en_q;
    logic              valid_q;
    logic              busy_q;
    logic              done_q;
    logic              sr_bit;
    logic              col_last;
    logic              last_row;
    logic              accept;
    logic              row_done;
    logic              in_shift;

    assign in_shift = (state == SHIFT);
    assign accept   = valid_q && bus.pix_ready;
    assign row_done = accept && col_last;
    assign last_row = (row == LAST_ROW);

    scan_row_shifter #(
        .COLS  (COLS),
        .COL_W (COL_W)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .load    (state == WAIT),
        .din     (bus.rom_data),
        .shift   (accept),
        .bit_out (sr_bit),
        .col     (col),
        .last    (col_last)
    );

    // Row sequencing: fetch, wait for ROM, shift out, repeat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            row        <= '0;
            frame_q    <= '0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            rom_en_q <= 1'b0;
            done_q   <= 1'b0;
            if (bus.abort) begin
                state   <= IDLE;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (bus.start) begin
                            state      <= FETCH;
                            row        <= '0;
                            rom_en_q   <= 1'b1;
                            rom_addr_q <= '0;
                            busy_q     <= 1'b1;
                        end
                    end
                    FETCH: begin
                        state <= WAIT;
                    end
                    WAIT: begin
                        state   <= SHIFT;
                        valid_q <= 1'b1;
                    end
                    SHIFT: begin
                        if (row_done) begin
                            valid_q  <= 1'b0;
                            rom_en_q <= 1'b1;
                            state    <= FETCH;
                            if (!last_row) begin
                                row        <= row + ADDR_W'(1);
                                rom_addr_q <= row + ADDR_W'(1);
                            end else begin
                                done_q     <= 1'b1;
                                frame_q    <= frame_q + 8'd1;
                                row        <= '0;
                                rom_addr_q <= '0;
                                if (!bus.loop) begin
                                    state    <= IDLE;
                                    rom_en_q <= 1'b0;
                                    busy_q   <= 1'b0;
                                end
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.rom_en    = rom_en_q;
    assign bus.rom_addr  = rom_addr_q;
    assign bus.pix_valid = valid_q;
    assign bus.pix_data  = sr_bit;
    assign bus.pix_row   = row;
    assign bus.pix_col   = col;
    assign bus.pix_eol   = in_shift && col_last;
    assign bus.pix_eof   = in_shift && col_last && last_row;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.frame_cnt = frame_q;

endmodule

// File: tb/tb_ganesha_scan_ctrl.sv
// tb_ganesha_scan_ctrl: vector table, directed frame scenarios and
// random back-pressure against a pixel-index reference model.
module tb_ganesha_scan_ctrl;

    localparam logic [63:0] ROM_BASE = 64'h8000_0000_0000_0001;
    localparam int NROWS = 32;
    localparam int NCOLS = 64;
    localparam int NPIX  = NROWS * NCOLS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   k = 0;
    int   rmode = 0;
    int   idle_cnt = 0;
    int   n;

    ganesha_scan_ctrl_if bus ();

    ganesha_scan_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ROM model: registered read, one cycle after rom_en
    always @(posedge clk) begin
        if (bus.rom_en) bus.rom_data <= ROM_BASE ^ 64'(bus.rom_addr);
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({bus.pix_valid, bus.pix_data, bus.pix_row,
                    bus.pix_col, bus.pix_eol, bus.pix_eof,
                    bus.rom_en, bus.rom_addr, bus.busy,
                    bus.done, bus.frame_cnt});
    endfunction

    // Reference model: frame = NPIX pixels in row-major order.
    int   exp_idx = 0;
    int   fetch_idx = 0;
    int   m_frames = 0;
    logic done_exp = 1'b0;

    always @(negedge clk) begin
        int r;
        int c;
        logic [63:0] w;
        if (rst) begin
            exp_idx   = 0;
            fetch_idx = 0;
            m_frames  = 0;
            done_exp  = 1'b0;
        end else begin
            chk("done", 64'(bus.done), 64'(done_exp));
            if (done_exp) m_frames++;
            chk("frame_cnt", 64'(bus.frame_cnt), 64'(m_frames % 256));
            if (bus.rom_en) begin
                chk("rom_addr", 64'(bus.rom_addr), 64'(fetch_idx));
                fetch_idx = (fetch_idx + 1) % NROWS;
            end
            if (bus.pix_valid) begin
                r = exp_idx / NCOLS;
                c = exp_idx % NCOLS;
                w = ROM_BASE ^ 64'(r);
                chk("pixel",
                    64'({bus.pix_data, bus.pix_row, bus.pix_col,
                         bus.pix_eol, bus.pix_eof}),
                    64'({w[63-c], 5'(r), 6'(c), c == NCOLS - 1,
                         (r == NROWS - 1) && (c == NCOLS - 1)}));
            end
            if (bus.abort || (bus.start && !bus.busy)) begin
                exp_idx   = 0;
                fetch_idx = 0;
                done_exp  = 1'b0;
            end else begin
                done_exp = bus.pix_valid && bus.pix_ready &&
                           (exp_idx == NPIX - 1);
                if (bus.pix_valid && bus.pix_ready)
                    exp_idx = (exp_idx + 1) % NPIX;
            end
        end
    end

    task automatic drive_ready();
        case (rmode)
            1: bus.pix_ready = 1'b1;
            2: bus.pix_ready = ((k + 1) % 2) == 0;
            3: bus.pix_ready = ($urandom_range(3) != 0);
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
        if (!bus.busy) idle_cnt++;
        drive_ready();
    endtask

    task automatic kick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        k = 0;
        idle_cnt = 0;
        drive_ready();
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = -1;
        while (cyc < 0) begin
            tick();
            if (bus.done) cyc = k;
            else if (k >= limit) begin
                chk("done_timeout", 64'(bus.done), 64'd1);
                cyc = k;
            end
        end
    endtask

    typedef struct packed {
        logic       st;
        logic       rdy;
        logic       ab;
        logic       en;
        logic       bsy;
        logic       pv;
        logic       pd;
        logic [5:0] col;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int act;
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'd0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'd0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd1};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd2};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd2};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};

        bus.start = 1'b0;
        bus.loop = 1'b0;
        bus.abort = 1'b0;
        bus.pix_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", outs(), 64'd0);
        rst = 1'b0;
        tick();

        // vector table: latency, stall, ignored start, abort priority
        for (int i = 0; i < 11; i++) begin
            bus.start = tbl[i].st;
            bus.pix_ready = tbl[i].rdy;
            bus.abort = tbl[i].ab;
            tick();
            chk($sformatf("vec%0d_ctl", i),
                64'({bus.rom_en, bus.busy, bus.pix_valid, bus.done}),
                64'({tbl[i].en, tbl[i].bsy, tbl[i].pv, 1'b0}));
            if (tbl[i].pv)
                chk($sformatf("vec%0d_pix", i),
                    64'({bus.pix_data, bus.pix_col}),
                    64'({tbl[i].pd, tbl[i].col}));
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;

        // frame with ready high; extra starts while busy are ignored
        rmode = 1;
        kick();
        repeat (100) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (700) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(3000, n);
        chk("s1_frame_cycles", 64'(n), 64'd2112);
        chk("s1_end", 64'({bus.busy, bus.frame_cnt}), 64'({1'b0, 8'd1}));

        // ready toggling every cycle
        rmode = 2;
        kick();
        wait_done(6000, n);
        chk("s2_frame_cycles", 64'(n), 64'd4160);
        chk("s2_frame_cnt", 64'(bus.frame_cnt), 64'd2);

        // looping: three back-to-back frames
        rmode = 1;
        bus.loop = 1'b1;
        kick();
        wait_done(3000, n);
        chk("s3_done1", 64'(n), 64'd2112);
        wait_done(5000, n);
        chk("s3_done2", 64'(n), 64'd4224);
        chk("s3_no_gap", 64'(idle_cnt), 64'd0);
        bus.loop = 1'b0;
        wait_done(7000, n);
        chk("s3_done3", 64'(n), 64'd6336);
        chk("s3_end", 64'({bus.busy, bus.frame_cnt}), 64'({1'b0, 8'd5}));

        // random back-pressure
        rmode = 3;
        kick();
        wait_done(20000, n);
        chk("s4_frame_cnt", 64'(bus.frame_cnt), 64'd6);

        // abort at row 10 col 20, then rescan from row 0
        rmode = 1;
        kick();
        while (!(bus.pix_valid && bus.pix_row == 5'd10 &&
                 bus.pix_col == 6'd20) && k < 3000) tick();
        chk("s5_pos", 64'({bus.pix_row, bus.pix_col}),
            64'({5'd10, 6'd20}));
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("s5_idle", 64'({bus.busy, bus.pix_valid, bus.done}), 64'd0);
        repeat (5) tick();
        chk("s5_frame_cnt", 64'(bus.frame_cnt), 64'd6);
        kick();
        tick();
        tick();
        chk("s5_rescan", 64'({bus.pix_valid, bus.pix_row, bus.pix_col}),
            64'({1'b1, 5'd0, 6'd0}));
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;

        // asynchronous reset mid-shift
        kick();
        while (!(bus.pix_valid && bus.pix_row == 5'd3 &&
                 bus.pix_col == 6'd5) && k < 1000) tick();
        chk("s6_pos", 64'({bus.pix_row, bus.pix_col}),
            64'({5'd3, 6'd5}));
        #2;
        rst = 1'b1;
        #1;
        chk("s6_rst_async", outs(), 64'd0);
        tick();
        rst = 1'b0;
        act = 0;
        repeat (20) begin
            tick();
            if (bus.busy || bus.rom_en || bus.pix_valid) act++;
        end
        chk("s6_stay_idle", 64'(act), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
